exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_if.sv | 46 ++++
 rtl/exec_ctrl.sv | 176 +++++++++++++++++
 tb/tb_exec_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// exec_ctrl_if -- control/status bundle between the execution controller and
// its surroundings (rate divider, front panel, datapath).
//
// Signals
//   tick       pacing strobe, one cycle wide, from the rate divider
//   run_sw     free-run request level (1 = run)
//   step_key   raw asynchronous active-low single-step pushbutton
//   bp_en      breakpoint compare enable
//   bp_addr    breakpoint PC value
//   pc         current datapath program counter
//   cpu_en     one-cycle enable for PC, register bank and memory write
//   state      controller state: HALT=00, RUN=01, STEP=10, BREAK=11
//   instr_cnt  count of executed instructions (wraps at 16 bits)
//   bp_hit     high while the controller sits in BREAK
//
// Handshake: there is no valid/ready pair. tick is a fire-and-forget
// strobe. A qualifying tick sampled on a rising edge is answered by
// cpu_en=1 for exactly the following cycle. A tick is not held or queued.
// All other inputs are levels that are sampled every cycle.
//
// Modports: master drives the inputs (bench / system), slave is the
// controller.
// ---------------------------------------------------------------------------
interface exec_ctrl_if;
  logic        tick;
  logic        run_sw;
  logic        step_key;
  logic        bp_en;
  logic [7:0]  bp_addr;
  logic [7:0]  pc;
  logic        cpu_en;
  logic [1:0]  state;
  logic [15:0] instr_cnt;
  logic        bp_hit;

  modport master (
    output tick, run_sw, step_key, bp_en, bp_addr, pc,
    input  cpu_en, state, instr_cnt, bp_hit
  );

  modport slave (
    input  tick, run_sw, step_key, bp_en, bp_addr, pc,
    output cpu_en, state, instr_cnt, bp_hit
  );
endinterface

// File: rtl/exec_ctrl.sv
// ---------------------------------------------------------------------------
// exec_ctrl -- execution controller for a small CPU datapath.
//
// Decides when the datapath advances one instruction (cpu_en), either in
// free run paced by tick, in single step from a debounced pushbutton, or
// not at all when halted or stopped at a breakpoint.
//
// Ports
//   clk   single system clock, all state changes on its rising edge
//   rst   synchronous active-low reset
//   bus   exec_ctrl_if.slave: tick, run_sw, step_key, bp_en, bp_addr, pc in;
//         cpu_en, state, instr_cnt, bp_hit out
//
// Parameter
//   DEB_CYCLES  clk cycles the synchronised key must be stable before a
//               level change is accepted
//
// Build option
//   EXEC_CTRL_BP_EN  defined: breakpoint compare and BREAK state are live.
//                    undefined: no comparator, bp_en/bp_addr/pc ignored,
//                    BREAK unreachable, bp_hit tied low.
// ---------------------------------------------------------------------------
module exec_ctrl #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  exec_ctrl_if.slave  bus
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    HALT  = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10,
    BREAK = 2'b11
  } state_t;

  // ---------------- key synchroniser and debouncer ----------------
  // The synchroniser resets to the idle (released) level so that reset
  // itself never looks like a press.
  logic          sync_ff1;
  logic          sync_ff2;
  logic          deb_level;
  logic          armed;
  logic          step_p;
  logic [CW-1:0] deb_cnt;
  logic          deb_busy;
  logic          deb_done;

  // armed is cleared by reset and set only once the key has been seen
  // stably released. A key held through reset release therefore gets its
  // debounced level pulled to 0 without producing a press.
  // The counter runs while the key differs from the debounced level, or
  // while waiting to see the key released for the first time.
  assign deb_busy = (sync_ff2 != deb_level) || (!armed && sync_ff2);
  assign deb_done = deb_busy && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_ff1  <= 1'b1;
      sync_ff2  <= 1'b1;
      deb_cnt   <= '0;
      deb_level <= 1'b1;
      armed     <= 1'b0;
      step_p    <= 1'b0;
    end else begin
      sync_ff1 <= bus.step_key;
      sync_ff2 <= sync_ff1;
      step_p   <= 1'b0;
      if (!deb_busy) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb_cnt   <= '0;
        deb_level <= sync_ff2;
        if (sync_ff2) begin
          armed <= 1'b1;
        end else if (armed) begin
          step_p <= 1'b1;
        end
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // ---------------- breakpoint compare ----------------
  logic bp_match;
`ifdef EXEC_CTRL_BP_EN
  assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);
`else
  assign bp_match = 1'b0;
`endif

  // ---------------- controller FSM ----------------
  state_t      state_q;
  logic        cpu_en_q;
  logic        bp_hit_q;
  logic [15:0] instr_cnt_q;
  logic        tick_ok;

  // Gating on cpu_en_q keeps cpu_en from ever being high two cycles in a
  // row, even if tick is held high.
  assign tick_ok = bus.tick && !cpu_en_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= HALT;
      cpu_en_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
      instr_cnt_q <= '0;
    end else begin
      cpu_en_q    <= 1'b0;
      instr_cnt_q <= instr_cnt_q + {15'd0, cpu_en_q};
      case (state_q)
        HALT: begin
          if (bus.run_sw) begin
            state_q <= RUN;
          end else if (step_p) begin
            state_q <= STEP;
          end
        end
        RUN: begin
          // Dropping run_sw wins over a tick in the same cycle.
          if (!bus.run_sw) begin
            state_q <= HALT;
          end else if (tick_ok) begin
            if (bp_match) begin
              state_q  <= BREAK;
              bp_hit_q <= 1'b1;
            end else begin
              cpu_en_q <= 1'b1;
            end
          end
        end
        STEP: begin
          // No breakpoint compare here: stepping off a breakpoint must
          // execute the instruction sitting at it.
          if (tick_ok) begin
            cpu_en_q <= 1'b1;
            state_q  <= HALT;
          end
        end
        BREAK: begin
          if (step_p) begin
            state_q  <= STEP;
            bp_hit_q <= 1'b0;
          end else if (!bus.run_sw) begin
            state_q  <= HALT;
            bp_hit_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= HALT;
          bp_hit_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.state     = state_q;
  assign bus.instr_cnt = instr_cnt_q;

`ifdef EXEC_CTRL_BP_EN
  assign bus.bp_hit = bp_hit_q;
`else
  assign bus.bp_hit = 1'b0;
  // Breakpoint inputs are deliberately ignored in this build.
  logic unused_bp;
  assign unused_bp = ^{bus.bp_en, bus.bp_addr, bus.pc, bp_hit_q};
`endif

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

  localparam int DEB = 4;

  logic clk;
  logic rst;
  exec_ctrl_if bus ();

  exec_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          pass_cnt;
  int          total_cnt;
  logic [15:0] exp_cnt;
  int          double_cnt;
  logic        prev_en;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Counts cpu_en high in two consecutive cycles.
  initial begin
    double_cnt = 0;
    prev_en    = 1'b0;
  end
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.cpu_en === 1'b1 && prev_en) double_cnt++;
    prev_en = (rst === 1'b1) && (bus.cpu_en === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // tick high for one cycle; returns 1 time unit after the edge that sampled it
  task automatic pulse_tick();
    bus.tick = 1'b1;
    cycle(1);
    bus.tick = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input int limit);
    for (int i = 0; i < limit && bus.state !== s; i++) cycle(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    cycle(3);
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL reset_state: got %b want 00", bus.state); else pass_cnt++;
    total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL reset_cpu_en: got %b want 0", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.instr_cnt !== 16'h0000) $display("FAIL reset_cnt: got %h want 0000", bus.instr_cnt); else pass_cnt++;
    total_cnt++; if (bus.bp_hit !== 1'b0) $display("FAIL reset_bp_hit: got %b want 0", bus.bp_hit); else pass_cnt++;
    rst = 1'b1;
    cycle(1);
    exp_cnt = 16'h0000;
  endtask

  task automatic test_run();
    bus.run_sw = 1'b1;
    cycle(1);
    total_cnt++; if (bus.state !== 2'b01) $display("FAIL run_enter: got %b want 01", bus.state); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      cycle(8);
      pulse_tick();
      total_cnt++; if (bus.cpu_en !== 1'b1) $display("FAIL run_pulse%0d: cpu_en=%b want 1", i, bus.cpu_en); else pass_cnt++;
      exp_cnt++;
      cycle(1);
      total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL run_after%0d: cpu_en=%b want 0", i, bus.cpu_en); else pass_cnt++;
    end
    total_cnt++; if (bus.instr_cnt !== 16'd5) $display("FAIL run_cnt: got %0d want 5", bus.instr_cnt); else pass_cnt++;
    total_cnt++; if (double_cnt !== 0) $display("FAIL run_double: got %0d double pulses want 0", double_cnt); else pass_cnt++;
  endtask

  task automatic test_run_stop();
    bus.run_sw = 1'b0;
    bus.tick   = 1'b1;
    cycle(1);
    bus.tick   = 1'b0;
    total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL stop_cpu_en: got %b want 0", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL stop_state: got %b want 00", bus.state); else pass_cnt++;
    cycle(1);
    total_cnt++; if (bus.instr_cnt !== exp_cnt) $display("FAIL stop_cnt: got %0d want %0d", bus.instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_step();
    // bounce in the first three cycles, then held low
    bus.step_key = 1'b0; cycle(1);
    bus.step_key = 1'b1; cycle(1);
    bus.step_key = 1'b0; cycle(18);
    total_cnt++; if (bus.state !== 2'b10) $display("FAIL step_enter: got %b want 10", bus.state); else pass_cnt++;
    bus.run_sw = 1'b1;
    cycle(2);
    total_cnt++; if (bus.state !== 2'b10) $display("FAIL step_run_sw: got %b want 10", bus.state); else pass_cnt++;
    bus.run_sw = 1'b0;
    cycle(1);
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1) $display("FAIL step_pulse: cpu_en=%b want 1", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL step_halt: got %b want 00", bus.state); else pass_cnt++;
    exp_cnt++;
    cycle(1);
    total_cnt++; if (bus.instr_cnt !== exp_cnt) $display("FAIL step_cnt: got %0d want %0d", bus.instr_cnt, exp_cnt); else pass_cnt++;
    cycle(20);
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL step_held_once: got %b want 00", bus.state); else pass_cnt++;
    bus.step_key = 1'b1;
    cycle(10);
  endtask

  task automatic test_breakpoint();
    bus.run_sw  = 1'b1;
    bus.bp_en   = 1'b1;
    bus.bp_addr = 8'h05;
    bus.pc      = 8'h05;
    cycle(1);
    total_cnt++; if (bus.state !== 2'b01) $display("FAIL bp_run: got %b want 01", bus.state); else pass_cnt++;
`ifdef EXEC_CTRL_BP_EN
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL bp_no_en: cpu_en=%b want 0", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.state !== 2'b11) $display("FAIL bp_state: got %b want 11", bus.state); else pass_cnt++;
    total_cnt++; if (bus.bp_hit !== 1'b1) $display("FAIL bp_hit: got %b want 1", bus.bp_hit); else pass_cnt++;
    cycle(3);
    pulse_tick();
    total_cnt++; if (bus.state !== 2'b11 || bus.cpu_en !== 1'b0) $display("FAIL bp_stay: state=%b cpu_en=%b want 11/0", bus.state, bus.cpu_en); else pass_cnt++;
    bus.step_key = 1'b0;
    wait_state(2'b10, 30);
    total_cnt++; if (bus.state !== 2'b10) $display("FAIL bp_step: got %b want 10", bus.state); else pass_cnt++;
    total_cnt++; if (bus.bp_hit !== 1'b0) $display("FAIL bp_hit_clr: got %b want 0", bus.bp_hit); else pass_cnt++;
    bus.run_sw   = 1'b0;
    bus.step_key = 1'b1;
    cycle(8);
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1) $display("FAIL bp_step_en: cpu_en=%b want 1", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL bp_step_halt: got %b want 00", bus.state); else pass_cnt++;
    exp_cnt++;
    // re-entering RUN while still sitting on the breakpoint breaks again
    bus.run_sw = 1'b1;
    cycle(1);
    pulse_tick();
    total_cnt++; if (bus.state !== 2'b11 || bus.cpu_en !== 1'b0) $display("FAIL bp_again: state=%b cpu_en=%b want 11/0", bus.state, bus.cpu_en); else pass_cnt++;
    bus.run_sw = 1'b0;
    cycle(1);
    total_cnt++; if (bus.state !== 2'b00 || bus.bp_hit !== 1'b0) $display("FAIL bp_to_halt: state=%b bp_hit=%b want 00/0", bus.state, bus.bp_hit); else pass_cnt++;
    // disabling the compare takes effect on the next tick
    bus.run_sw = 1'b1;
    bus.bp_en  = 1'b0;
    cycle(1);
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1 || bus.state !== 2'b01) $display("FAIL bp_disabled: cpu_en=%b state=%b want 1/01", bus.cpu_en, bus.state); else pass_cnt++;
    exp_cnt++;
`else
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1) $display("FAIL nobp_en: cpu_en=%b want 1", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.state !== 2'b01) $display("FAIL nobp_state: got %b want 01", bus.state); else pass_cnt++;
    total_cnt++; if (bus.bp_hit !== 1'b0) $display("FAIL nobp_hit: got %b want 0", bus.bp_hit); else pass_cnt++;
    exp_cnt++;
    cycle(3);
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1 || bus.state !== 2'b01) $display("FAIL nobp_again: cpu_en=%b state=%b want 1/01", bus.cpu_en, bus.state); else pass_cnt++;
    exp_cnt++;
`endif
    bus.run_sw = 1'b0;
    bus.bp_en  = 1'b0;
    bus.pc     = 8'h00;
    cycle(2);
    total_cnt++; if (bus.instr_cnt !== exp_cnt) $display("FAIL bp_cnt: got %0d want %0d", bus.instr_cnt, exp_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap();
    // stand-in for 65535 prior instructions
    force dut.instr_cnt_q = 16'hFFFF;
    cycle(2);
    release dut.instr_cnt_q;
    cycle(1);
    bus.run_sw = 1'b1;
    cycle(1);
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1) $display("FAIL wrap_en: cpu_en=%b want 1", bus.cpu_en); else pass_cnt++;
    cycle(1);
    total_cnt++; if (bus.instr_cnt !== 16'h0000) $display("FAIL wrap_cnt: got %h want 0000", bus.instr_cnt); else pass_cnt++;
    cycle(8);
    pulse_tick();
    cycle(1);
    total_cnt++; if (bus.instr_cnt !== 16'h0001) $display("FAIL wrap_next: got %h want 0001", bus.instr_cnt); else pass_cnt++;
    bus.run_sw = 1'b0;
    cycle(1);
  endtask

  task automatic test_reset_in_step();
    bus.step_key = 1'b0;
    wait_state(2'b10, 30);
    total_cnt++; if (bus.state !== 2'b10) $display("FAIL rstep_enter: got %b want 10", bus.state); else pass_cnt++;
    bus.step_key = 1'b1;
    cycle(8);
    bus.tick = 1'b1;
    rst      = 1'b0;
    cycle(1);
    bus.tick = 1'b0;
    total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL rstep_cpu_en: got %b want 0", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL rstep_state: got %b want 00", bus.state); else pass_cnt++;
    total_cnt++; if (bus.instr_cnt !== 16'h0000) $display("FAIL rstep_cnt: got %h want 0000", bus.instr_cnt); else pass_cnt++;
    rst = 1'b1;
    cycle(1);
    total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL rstep_late: cpu_en=%b want 0", bus.cpu_en); else pass_cnt++;
    exp_cnt = 16'h0000;
    cycle(8);
  endtask

  task automatic test_reset_in_run();
    bus.run_sw = 1'b1;
    cycle(4);
    bus.tick = 1'b1;
    rst      = 1'b0;
    cycle(1);
    bus.tick   = 1'b0;
    bus.run_sw = 1'b0;
    rst        = 1'b1;
    total_cnt++; if (bus.cpu_en !== 1'b0 || bus.state !== 2'b00) $display("FAIL rrun_reset: cpu_en=%b state=%b want 0/00", bus.cpu_en, bus.state); else pass_cnt++;
    cycle(1);
    total_cnt++; if (bus.cpu_en !== 1'b0) $display("FAIL rrun_late: cpu_en=%b want 0", bus.cpu_en); else pass_cnt++;
    total_cnt++; if (bus.instr_cnt !== 16'h0000) $display("FAIL rrun_cnt: got %h want 0000", bus.instr_cnt); else pass_cnt++;
  endtask

  task automatic test_key_through_reset();
    bus.step_key = 1'b0;
    cycle(3);
    rst = 1'b0;
    cycle(3);
    rst = 1'b1;
    cycle(25);
    total_cnt++; if (bus.state !== 2'b00) $display("FAIL key_rst_held: got %b want 00", bus.state); else pass_cnt++;
    bus.step_key = 1'b1;
    cycle(12);
    bus.step_key = 1'b0;
    wait_state(2'b10, 30);
    total_cnt++; if (bus.state !== 2'b10) $display("FAIL key_rst_press: got %b want 10", bus.state); else pass_cnt++;
    bus.step_key = 1'b1;
    pulse_tick();
    total_cnt++; if (bus.cpu_en !== 1'b1 || bus.state !== 2'b00) $display("FAIL key_rst_step: cpu_en=%b state=%b want 1/00", bus.cpu_en, bus.state); else pass_cnt++;
    cycle(10);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    exp_cnt      = 16'h0000;
    rst          = 1'b0;
    bus.tick     = 1'b0;
    bus.run_sw   = 1'b0;
    bus.step_key = 1'b1;
    bus.bp_en    = 1'b0;
    bus.bp_addr  = 8'h00;
    bus.pc       = 8'h00;

    test_reset();
    test_run();
    test_run_stop();
    test_step();
    test_breakpoint();
    test_wrap();
    test_reset_in_step();
    test_reset_in_run();
    test_key_through_reset();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
